// File: rtl/sdram_burst_sched.sv
// Burst scheduler: picks write/read SDRAM bursts from FIFO fill levels,
// walks linear frame addresses with wrap, and ping-pongs frame banks.
module sdram_burst_sched #(
    parameter int unsigned MAX_ADDR      = 307200,
    parameter int unsigned BURST_LEN     = 512,
    parameter int unsigned RD_FIFO_DEPTH = 1024,
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned LEN_W         = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              pingpang_en,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              rd_enable,
    input  logic [LEN_W:0]    wr_fifo_cnt,
    input  logic [LEN_W:0]    rd_fifo_cnt,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    input  logic              sdram_ack,
    input  logic              sdram_done,
    output logic [ADDR_W-1:0] burst_addr,
    output logic [LEN_W-1:0]  burst_len,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_wr_done
);

    localparam int unsigned OFF_W = ADDR_W - 1;
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam logic [OFF_W-1:0] MAX_OFF   = OFF_W'(MAX_ADDR);
    localparam logic [OFF_W-1:0] BURST_OFF = OFF_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_DEPTH  = CNT_W'(RD_FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;
    logic             wr_pend;
    logic             rd_pend;
    logic             last_wr;     // last grant was a write; reset = read

    logic [OFF_W-1:0] wr_rem_c;
    logic [OFF_W-1:0] rd_rem_c;
    logic [LEN_W-1:0] wr_len_c;
    logic [LEN_W-1:0] rd_len_c;
    logic [OFF_W-1:0] end_off_c;
    logic             wr_elig_c;
    logic             rd_elig_c;
    logic             wr_apply_c;
    logic             rd_apply_c;

    // Burst lengths clipped at frame end, eligibility and burst end offset
    always_comb begin
        wr_rem_c   = MAX_OFF - wr_off;
        rd_rem_c   = MAX_OFF - rd_off;
        wr_len_c   = (wr_rem_c < BURST_OFF) ? LEN_W'(wr_rem_c) : LEN_W'(BURST_LEN);
        rd_len_c   = (rd_rem_c < BURST_OFF) ? LEN_W'(rd_rem_c) : LEN_W'(BURST_LEN);
        wr_elig_c  = (wr_fifo_cnt >= CNT_W'(wr_len_c));
        rd_elig_c  = rd_enable && (rd_fifo_cnt <= (RD_DEPTH - CNT_W'(rd_len_c)));
        wr_apply_c = wr_pend | wr_load;
        rd_apply_c = rd_pend | rd_load;
        end_off_c  = ((state == RD_BUSY) ? rd_off : wr_off) + OFF_W'(burst_len);
    end

    // Scheduler FSM with registered request/address/bank outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_off        <= '0;
            rd_off        <= '0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
            last_wr       <= 1'b0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
            burst_addr    <= '0;
            burst_len     <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            frame_wr_done <= 1'b0;
        end else begin
            frame_wr_done <= 1'b0;
            if (wr_load) wr_pend <= 1'b1;
            if (rd_load) rd_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_apply_c || rd_apply_c) begin
                        // loads win over arbitration for this cycle
                        if (wr_apply_c) begin
                            wr_off  <= '0;
                            wr_bank <= 1'b0;
                            wr_pend <= 1'b0;
                        end
                        if (rd_apply_c) begin
                            rd_off  <= '0;
                            rd_bank <= 1'b0;
                            rd_pend <= 1'b0;
                        end
                    end else if (init_done) begin
                        if (wr_elig_c && (!rd_elig_c || !last_wr)) begin
                            state        <= WR_REQ;
                            sdram_wr_req <= 1'b1;
                            burst_addr   <= {pingpang_en & wr_bank, wr_off};
                            burst_len    <= wr_len_c;
                            last_wr      <= 1'b1;
                        end else if (rd_elig_c) begin
                            state        <= RD_REQ;
                            sdram_rd_req <= 1'b1;
                            burst_addr   <= {pingpang_en & rd_bank, rd_off};
                            burst_len    <= rd_len_c;
                            last_wr      <= 1'b0;
                        end
                    end
                end
                WR_REQ: begin
                    if (sdram_ack) begin
                        sdram_wr_req <= 1'b0;
                        state        <= WR_BUSY;
                    end
                end
                RD_REQ: begin
                    if (sdram_ack) begin
                        sdram_rd_req <= 1'b0;
                        state        <= RD_BUSY;
                    end
                end
                WR_BUSY: begin
                    if (sdram_done) begin
                        state <= IDLE;
                        if (end_off_c == MAX_OFF) begin
                            wr_off        <= '0;
                            frame_wr_done <= 1'b1;
                            if (pingpang_en) wr_bank <= ~wr_bank;
                        end else begin
                            wr_off <= end_off_c;
                        end
                    end
                end
                RD_BUSY: begin
                    if (sdram_done) begin
                        state <= IDLE;
                        if (end_off_c == MAX_OFF) begin
                            rd_off <= '0;
                            // follow the frame the writer has just finished
                            if (pingpang_en) rd_bank <= ~wr_bank;
                        end else begin
                            rd_off <= end_off_c;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (!pingpang_en) begin
                wr_bank <= 1'b0;
                rd_bank <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Directed bench for sdram_burst_sched with a 1200-word frame.
module tb_sdram_burst_sched;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_done;
    logic              pingpang_en;
    logic              wr_load;
    logic              rd_load;
    logic              rd_enable;
    logic [LEN_W:0]    wr_fifo_cnt;
    logic [LEN_W:0]    rd_fifo_cnt;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic              sdram_ack;
    logic              sdram_done;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic              wr_bank;
    logic              rd_bank;
    logic              frame_wr_done;

    int errors = 0;
    int checks = 0;

    sdram_burst_sched #(
        .MAX_ADDR(1200), .BURST_LEN(512), .RD_FIFO_DEPTH(1024),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .pingpang_en(pingpang_en),
        .wr_load(wr_load), .rd_load(rd_load), .rd_enable(rd_enable),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_ack(sdram_ack), .sdram_done(sdram_done),
        .burst_addr(burst_addr), .burst_len(burst_len),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_wr_done(frame_wr_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic pp);
        rst_n = 1'b0; init_done = 1'b0; pingpang_en = pp;
        wr_load = 1'b0; rd_load = 1'b0; rd_enable = 1'b0;
        wr_fifo_cnt = '0; rd_fifo_cnt = '0; sdram_ack = 1'b0; sdram_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for any request; sampled on falling edges
    task automatic wait_req(output logic w, output logic r, output bit ok);
        ok = 1'b0; w = 1'b0; r = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) begin
                w = sdram_wr_req; r = sdram_rd_req; ok = 1'b1;
            end
        end
    endtask

    // One-cycle ack followed by one-cycle done
    task automatic ack_done;
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0; sdram_done = 1'b1;
        @(negedge clk);
        sdram_done = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        checks++;
        if ({sdram_wr_req, sdram_rd_req, wr_bank, rd_bank, frame_wr_done} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000",
                {sdram_wr_req, sdram_rd_req, wr_bank, rd_bank, frame_wr_done});
        end
        checks++;
        if (burst_addr !== 24'h0 || burst_len !== 10'd0) begin
            errors++; $display("FAIL reset_addr_len: got %h/%0d expected 0/0", burst_addr, burst_len);
        end
    endtask

    task automatic test_write_only;
        logic w, r; bit ok;
        logic [23:0] ea [4] = '{24'd0, 24'd512, 24'd1024, 24'h800000};
        logic [9:0]  el [4] = '{10'd512, 10'd512, 10'd176, 10'd512};
        do_reset(1'b1);
        init_done = 1'b1; wr_fifo_cnt = 11'd600;
        for (int i = 0; i < 4; i++) begin
            wait_req(w, r, ok);
            checks++;
            if (!ok || w !== 1'b1 || r !== 1'b0) begin
                errors++; $display("FAIL wr_req[%0d]: got ok=%0d w=%b r=%b expected 1/1/0", i, ok, w, r);
            end
            checks++;
            if (burst_addr !== ea[i] || burst_len !== el[i]) begin
                errors++; $display("FAIL wr_burst[%0d]: got %h/%0d expected %h/%0d",
                    i, burst_addr, burst_len, ea[i], el[i]);
            end
            ack_done();
            if (i < 3) begin
                checks++;
                if (frame_wr_done !== (i == 2)) begin
                    errors++; $display("FAIL frame_wr_done[%0d]: got %b expected %b", i, frame_wr_done, i == 2);
                end
            end
            if (i == 2) begin
                checks++;
                if (wr_bank !== 1'b1) begin
                    errors++; $display("FAIL wr_bank_toggle: got %b expected 1", wr_bank);
                end
                @(negedge clk);
                checks++;
                if (frame_wr_done !== 1'b0) begin
                    errors++; $display("FAIL frame_wr_done_width: got %b expected 0", frame_wr_done);
                end
            end
        end
        wr_fifo_cnt = '0;
    endtask

    task automatic test_back_to_back;
        logic w, r; bit ok;
        logic [23:0] ea [4] = '{24'd0, 24'd0, 24'd512, 24'd512};
        do_reset(1'b1);
        init_done = 1'b1; wr_fifo_cnt = 11'd600; rd_enable = 1'b1; rd_fifo_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            wait_req(w, r, ok);
            checks++;
            if (!ok || w !== (i % 2 == 0) || r !== (i % 2 == 1)) begin
                errors++; $display("FAIL rr_grant[%0d]: got ok=%0d w=%b r=%b expected w=%b",
                    i, ok, w, r, i % 2 == 0);
            end
            checks++;
            if (burst_addr !== ea[i]) begin
                errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, burst_addr, ea[i]);
            end
            if (i == 0) begin
                repeat (3) @(negedge clk);
                checks++;
                if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0 || burst_addr !== 24'd0) begin
                    errors++; $display("FAIL req_hold: got w=%b r=%b a=%h expected 1/0/0",
                        sdram_wr_req, sdram_rd_req, burst_addr);
                end
                sdram_ack = 1'b1;
                @(negedge clk);
                sdram_ack = 1'b0;
                checks++;
                if (sdram_wr_req !== 1'b0) begin
                    errors++; $display("FAIL req_drop: got %b expected 0", sdram_wr_req);
                end
                sdram_done = 1'b1;
                @(negedge clk);
                sdram_done = 1'b0;
            end else begin
                ack_done();
            end
        end
        wr_fifo_cnt = '0; rd_enable = 1'b0;
    endtask

    task automatic test_read_gating;
        logic w, r; bit ok;
        int seen;
        do_reset(1'b1);
        init_done = 1'b1; rd_enable = 1'b1; rd_fifo_cnt = 11'd513;
        seen = 0;
        repeat (10) begin @(negedge clk); if (sdram_rd_req) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rd_gate_513: got %0d req cycles expected 0", seen);
        end
        rd_fifo_cnt = 11'd512;
        wait_req(w, r, ok);
        checks++;
        if (!ok || r !== 1'b1 || w !== 1'b0 || burst_len !== 10'd512) begin
            errors++; $display("FAIL rd_gate_512: got ok=%0d r=%b w=%b len=%0d expected 1/1/0/512",
                ok, r, w, burst_len);
        end
        ack_done();
        rd_enable = 1'b0; rd_fifo_cnt = '0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (sdram_rd_req) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rd_gate_disabled: got %0d req cycles expected 0", seen);
        end
    endtask

    task automatic test_pingpong;
        logic w, r; bit ok;
        logic [23:0] ea [4] = '{24'd0, 24'd0, 24'h800000, 24'd0};
        logic        ew [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        er [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset(1'b1);
        init_done = 1'b1; wr_fifo_cnt = 11'd600;
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 3; b++) begin
                wait_req(w, r, ok);
                checks++;
                if (!ok || w !== (f % 2 == 0) || r !== (f % 2 == 1)) begin
                    errors++; $display("FAIL pp_type[%0d.%0d]: got ok=%0d w=%b r=%b", f, b, ok, w, r);
                end
                if (b == 0) begin
                    checks++;
                    if (burst_addr !== ea[f]) begin
                        errors++; $display("FAIL pp_addr[%0d]: got %h expected %h", f, burst_addr, ea[f]);
                    end
                end
                ack_done();
            end
            wr_fifo_cnt = (f % 2 == 0) ? 11'd0 : 11'd600;
            rd_enable   = (f % 2 == 0);
            checks++;
            if (wr_bank !== ew[f] || rd_bank !== er[f]) begin
                errors++; $display("FAIL pp_banks[%0d]: got wr=%b rd=%b expected wr=%b rd=%b",
                    f, wr_bank, rd_bank, ew[f], er[f]);
            end
        end
        wr_fifo_cnt = '0; rd_enable = 1'b0;

        do_reset(1'b0);
        init_done = 1'b1; wr_fifo_cnt = 11'd600;
        for (int b = 0; b < 4; b++) begin
            wait_req(w, r, ok);
            if (b == 3) begin
                checks++;
                if (!ok || burst_addr !== 24'd0) begin
                    errors++; $display("FAIL nopp_addr: got ok=%0d %h expected 000000", ok, burst_addr);
                end
            end
            ack_done();
            if (b == 2) begin
                checks++;
                if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin
                    errors++; $display("FAIL nopp_banks: got wr=%b rd=%b expected 0/0", wr_bank, rd_bank);
                end
            end
        end
        wr_fifo_cnt = '0;
    endtask

    task automatic test_load;
        logic w, r; bit ok;
        do_reset(1'b1);
        init_done = 1'b1; wr_fifo_cnt = 11'd600;
        for (int b = 0; b < 3; b++) begin
            wait_req(w, r, ok);
            ack_done();
        end
        wait_req(w, r, ok);
        checks++;
        if (!ok || burst_addr !== 24'h800000) begin
            errors++; $display("FAIL load_pre_addr: got ok=%0d %h expected 800000", ok, burst_addr);
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0; wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        @(negedge clk);
        sdram_done = 1'b1;
        @(negedge clk);
        sdram_done = 1'b0;
        wait_req(w, r, ok);
        checks++;
        if (!ok || w !== 1'b1 || burst_addr !== 24'd0 || burst_len !== 10'd512) begin
            errors++; $display("FAIL load_next: got ok=%0d w=%b %h/%0d expected 1/1/000000/512",
                ok, w, burst_addr, burst_len);
        end
        checks++;
        if (wr_bank !== 1'b0) begin
            errors++; $display("FAIL load_bank: got %b expected 0", wr_bank);
        end
        ack_done();
        wr_fifo_cnt = '0;
    endtask

    task automatic test_reset_mid_burst;
        logic w, r; bit ok;
        int seen;
        do_reset(1'b1);
        init_done = 1'b1; wr_fifo_cnt = 11'd600;
        wait_req(w, r, ok);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        rst_n = 1'b0; init_done = 1'b0;
        #1;
        checks++;
        if (burst_len !== 10'd0 || burst_addr !== 24'd0 || sdram_wr_req !== 1'b0) begin
            errors++; $display("FAIL async_reset: got len=%0d addr=%h req=%b expected 0/0/0",
                burst_len, burst_addr, sdram_wr_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin @(negedge clk); if (sdram_wr_req || sdram_rd_req) seen++; end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL no_init_req: got %0d req cycles expected 0", seen);
        end
        init_done = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b1 || burst_addr !== 24'd0) begin
            errors++; $display("FAIL init_latency: got req=%b addr=%h expected 1/000000",
                sdram_wr_req, burst_addr);
        end
        ack_done();
        wr_fifo_cnt = '0;
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_back_to_back();
        test_read_gating();
        test_pingpong();
        test_load();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
